sound_sequencer: RTL and testbench

Note scheduler that owns the buzzer's `music_scale` input and shares it between a looping background melody and the game-event sound effects (landing, perfect landing, game-over jingle). It sits between the game FSM and `Buzzer`. Its registered `o_music_scale` drives the buzzer's 6-bit note code (0 = rest, 1..21 = C_LOW..B_HIGH). It replaces ad-hoc note selection in the top level with one fixed-priority sequencer.

---
 rtl/sound_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_sound_sequencer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sound_sequencer.sv
// Fixed-priority buzzer note scheduler: gameover jingle > landing effect > looping background melody.
// All outputs registered; an input or note boundary seen at one edge shows on the outputs after that edge.
module sound_sequencer #(
   parameter int BEAT_CYCLES = 6_250_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_bgm_en,
   input  logic       i_load_done,
   input  logic       i_perfect,
   input  logic       i_gameover,
   output logic [5:0] o_music_scale,
   output logic       o_busy,
   output logic [1:0] o_state
);

   localparam int CW = $clog2(2 * BEAT_CYCLES);
   localparam logic [CW-1:0] END1 = CW'(BEAT_CYCLES - 1);
   localparam logic [CW-1:0] END2 = CW'(2 * BEAT_CYCLES - 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_BGM    = 2'd1;
   localparam logic [1:0] S_EFFECT = 2'd2;
   localparam logic [1:0] S_OVER   = 2'd3;

   localparam logic [2:0] JIN_REST = 3'd6;

   logic [1:0]    state;
   logic [3:0]    bgm_idx;
   logic [2:0]    eff_idx;
   logic [2:0]    jin_idx;
   logic          perf_q;
   logic          gameover_q;
   logic [CW-1:0] note_cnt;

   logic [1:0]    n_state;
   logic [3:0]    n_bgm;
   logic [2:0]    n_eff;
   logic [2:0]    n_jin;
   logic          n_perf;
   logic [CW-1:0] n_cnt;
   logic [5:0]    n_note;
   logic          go_rise;
   logic          eff_end;
   logic          eff_last;

   function automatic logic [5:0] bgm_note(input logic [3:0] idx);
      case (idx)
         4'd0, 4'd1:   bgm_note = 6'd8;
         4'd2, 4'd3:   bgm_note = 6'd12;
         4'd4, 4'd5:   bgm_note = 6'd13;
         4'd6:         bgm_note = 6'd12;
         4'd8, 4'd9:   bgm_note = 6'd11;
         4'd10, 4'd11: bgm_note = 6'd10;
         4'd12, 4'd13: bgm_note = 6'd9;
         4'd14:        bgm_note = 6'd8;
         default:      bgm_note = 6'd0;
      endcase
   endfunction

   function automatic logic [5:0] eff_note(input logic perf, input logic [2:0] idx);
      if (perf) begin
         eff_note = (idx == 3'd0) ? 6'd11 : (idx == 3'd1) ? 6'd15 : 6'd0;
      end else begin
         eff_note = (idx == 3'd0) ? 6'd4 : 6'd0;
      end
   endfunction

   function automatic logic [5:0] jin_note(input logic [2:0] idx);
      case (idx)
         3'd0:    jin_note = 6'd12;
         3'd1:    jin_note = 6'd10;
         3'd2:    jin_note = 6'd8;
         3'd3:    jin_note = 6'd5;
         3'd4:    jin_note = 6'd3;
         3'd5:    jin_note = 6'd1;
         default: jin_note = 6'd0;
      endcase
   endfunction

   assign go_rise  = i_gameover & ~gameover_q;
   // Perfect effect is two one-beat notes; the normal effect is a single two-beat note.
   assign eff_end  = perf_q ? (note_cnt == END1) : (note_cnt == END2);
   assign eff_last = perf_q ? (eff_idx == 3'd1) : 1'b1;

   always_comb begin
      n_state = state;
      n_bgm   = bgm_idx;
      n_eff   = eff_idx;
      n_jin   = jin_idx;
      n_perf  = perf_q;
      n_cnt   = note_cnt + 1'b1;
      if (go_rise) begin
         n_state = S_OVER;
         n_jin   = 3'd0;
         n_cnt   = '0;
      end else begin
         case (state)
            S_IDLE: begin
               n_cnt = '0;
               if (i_load_done) begin
                  n_state = S_EFFECT;
                  n_eff   = 3'd0;
                  n_perf  = i_perfect;
               end else if (i_bgm_en) begin
                  n_state = S_BGM;
                  n_bgm   = 4'd0;
               end
            end
            S_BGM: begin
               // bgm_idx is left untouched on preemption so it doubles as the resume point.
               if (i_load_done) begin
                  n_state = S_EFFECT;
                  n_eff   = 3'd0;
                  n_perf  = i_perfect;
                  n_cnt   = '0;
               end else if (!i_bgm_en) begin
                  n_state = S_IDLE;
                  n_bgm   = 4'd0;
                  n_cnt   = '0;
               end else if (note_cnt == END1) begin
                  n_bgm = bgm_idx + 4'd1;
                  n_cnt = '0;
               end
            end
            S_EFFECT: begin
               if (i_load_done) begin
                  n_eff  = 3'd0;
                  n_perf = i_perfect;
                  n_cnt  = '0;
               end else if (eff_end) begin
                  n_cnt = '0;
                  if (!eff_last) begin
                     n_eff = eff_idx + 3'd1;
                  end else begin
                     n_eff = 3'd0;
                     if (i_bgm_en) begin
                        n_state = S_BGM;
                     end else begin
                        n_state = S_IDLE;
                        n_bgm   = 4'd0;
                     end
                  end
               end
            end
            default: begin
               if (!i_gameover) begin
                  n_state = i_bgm_en ? S_BGM : S_IDLE;
                  n_bgm   = 4'd0;
                  n_jin   = 3'd0;
                  n_cnt   = '0;
               end else if (jin_idx == JIN_REST) begin
                  n_cnt = '0;
               end else if (note_cnt == END2) begin
                  n_jin = jin_idx + 3'd1;
                  n_cnt = '0;
               end
            end
         endcase
      end
   end

   always_comb begin
      case (n_state)
         S_BGM:    n_note = bgm_note(n_bgm);
         S_EFFECT: n_note = eff_note(n_perf, n_eff);
         S_OVER:   n_note = jin_note(n_jin);
         default:  n_note = 6'd0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= S_IDLE;
         bgm_idx       <= 4'd0;
         eff_idx       <= 3'd0;
         jin_idx       <= 3'd0;
         perf_q        <= 1'b0;
         gameover_q    <= 1'b0;
         note_cnt      <= '0;
         o_music_scale <= 6'd0;
         o_busy        <= 1'b0;
      end else begin
         state         <= n_state;
         bgm_idx       <= n_bgm;
         eff_idx       <= n_eff;
         jin_idx       <= n_jin;
         perf_q        <= n_perf;
         gameover_q    <= i_gameover;
         note_cnt      <= n_cnt;
         o_music_scale <= n_note;
         o_busy        <= (n_state == S_EFFECT) || (n_state == S_OVER);
      end
   end

   assign o_state = state;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer with BEAT_CYCLES=10: stimulus queues expected outputs, a monitor checks each cycle.
module tb_sound_sequencer;

   logic       clk;
   logic       rst_n;
   logic       i_bgm_en;
   logic       i_load_done;
   logic       i_perfect;
   logic       i_gameover;
   logic [5:0] o_music_scale;
   logic       o_busy;
   logic [1:0] o_state;

   logic bgm_v, go_v, perf_v;
   logic [5:0] bgm_tab [16];
   logic [5:0] jin_tab [6];

   typedef struct {
      string      nm;
      logic [1:0] st;
      logic       bsy;
      logic [5:0] sc;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   sound_sequencer #(.BEAT_CYCLES(10)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_bgm_en      (i_bgm_en),
      .i_load_done   (i_load_done),
      .i_perfect     (i_perfect),
      .i_gameover    (i_gameover),
      .o_music_scale (o_music_scale),
      .o_busy        (o_busy),
      .o_state       (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input int got, input int want);
      n_tests++;
      if (got != want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
      end
   endtask

   // Apply inputs on the falling edge and queue what the outputs must show after the next rising edge.
   task automatic tick(input logic load, input logic [1:0] st, input logic bsy, input logic [5:0] sc, input string nm);
      exp_t e;
      @(negedge clk);
      i_load_done = load;
      i_bgm_en    = bgm_v;
      i_gameover  = go_v;
      i_perfect   = perf_v;
      e.nm = nm; e.st = st; e.bsy = bsy; e.sc = sc;
      exp_q.push_back(e);
   endtask

   task automatic hold(input int n, input logic [1:0] st, input logic bsy, input logic [5:0] sc, input string nm);
      for (int k = 0; k < n; k++) tick(1'b0, st, bsy, sc, nm);
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({e.nm, ".state"}, o_state, e.st);
            check({e.nm, ".busy"}, o_busy, e.bsy);
            check({e.nm, ".scale"}, o_music_scale, e.sc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bgm_tab[0] = 8;  bgm_tab[1] = 8;  bgm_tab[2] = 12;  bgm_tab[3] = 12;
      bgm_tab[4] = 13; bgm_tab[5] = 13; bgm_tab[6] = 12;  bgm_tab[7] = 0;
      bgm_tab[8] = 11; bgm_tab[9] = 11; bgm_tab[10] = 10; bgm_tab[11] = 10;
      bgm_tab[12] = 9; bgm_tab[13] = 9; bgm_tab[14] = 8;  bgm_tab[15] = 0;
      jin_tab[0] = 12; jin_tab[1] = 10; jin_tab[2] = 8; jin_tab[3] = 5; jin_tab[4] = 3; jin_tab[5] = 1;

      rst_n = 1'b0; i_bgm_en = 0; i_load_done = 0; i_perfect = 0; i_gameover = 0;
      bgm_v = 0; go_v = 0; perf_v = 0;
      #3;
      check("reset.scale", o_music_scale, 0);
      check("reset.state", o_state, 0);
      check("reset.busy", o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Background loop, including wrap after 16 entries
      tick(1'b0, 2'd0, 1'b0, 6'd0, "idle");
      bgm_v = 1;
      for (int e = 0; e < 16; e++) hold(10, 2'd1, 1'b0, bgm_tab[e], "bgm_loop");
      hold(10, 2'd1, 1'b0, 6'd8, "bgm_wrap");
      for (int e = 1; e < 4; e++) hold(10, 2'd1, 1'b0, bgm_tab[e], "bgm_pre");
      hold(3, 2'd1, 1'b0, 6'd13, "bgm_e4");

      // Perfect effect preempting entry 4, then resume with full-length 13
      perf_v = 1;
      tick(1'b1, 2'd2, 1'b1, 6'd11, "perf_start");
      perf_v = 0;
      hold(9, 2'd2, 1'b1, 6'd11, "perf_n0");
      hold(10, 2'd2, 1'b1, 6'd15, "perf_n1");
      hold(10, 2'd1, 1'b0, 6'd13, "bgm_resume");
      hold(10, 2'd1, 1'b0, 6'd13, "bgm_e5");
      hold(2, 2'd1, 1'b0, 6'd12, "bgm_e6");
      bgm_v = 0;
      tick(1'b0, 2'd0, 1'b0, 6'd0, "bgm_off");
      tick(1'b0, 2'd0, 1'b0, 6'd0, "idle2");

      // Normal effect from IDLE with a restarting second pulse
      tick(1'b1, 2'd2, 1'b1, 6'd4, "norm_start");
      hold(4, 2'd2, 1'b1, 6'd4, "norm_a");
      tick(1'b1, 2'd2, 1'b1, 6'd4, "norm_restart");
      hold(19, 2'd2, 1'b1, 6'd4, "norm_b");
      hold(3, 2'd0, 1'b0, 6'd0, "norm_end");

      // Gameover rise wins over a simultaneous load; loads in OVER are ignored
      bgm_v = 1; go_v = 1;
      tick(1'b1, 2'd3, 1'b1, 6'd12, "go_with_load");
      hold(19, 2'd3, 1'b1, 6'd12, "jin0");
      hold(5, 2'd3, 1'b1, 6'd10, "jin1a");
      perf_v = 1;
      tick(1'b1, 2'd3, 1'b1, 6'd10, "jin1_load");
      perf_v = 0;
      hold(14, 2'd3, 1'b1, 6'd10, "jin1b");
      for (int e = 2; e < 6; e++) hold(20, 2'd3, 1'b1, jin_tab[e], "jin");
      hold(3, 2'd3, 1'b1, 6'd0, "jin_rest");
      tick(1'b1, 2'd3, 1'b1, 6'd0, "rest_load");
      hold(3, 2'd3, 1'b1, 6'd0, "jin_rest2");

      // Gameover falls with BGM enabled: melody restarts at entry 0
      go_v = 0;
      tick(1'b0, 2'd1, 1'b0, 6'd8, "go_fall");
      hold(9, 2'd1, 1'b0, 6'd8, "bgm_r0");
      hold(10, 2'd1, 1'b0, 6'd8, "bgm_r1");
      hold(3, 2'd1, 1'b0, 6'd12, "bgm_r2");

      // Second jingle, interrupted by asynchronous reset between edges
      go_v = 1;
      tick(1'b0, 2'd3, 1'b1, 6'd12, "go_rise2");
      hold(19, 2'd3, 1'b1, 6'd12, "jin2_0");
      hold(5, 2'd3, 1'b1, 6'd10, "jin2_1");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      go_v = 0; bgm_v = 0;
      i_gameover = 0; i_bgm_en = 0; i_load_done = 0;
      #1;
      check("arst.scale", o_music_scale, 0);
      check("arst.state", o_state, 0);
      check("arst.busy", o_busy, 0);
      @(negedge clk);
      rst_n = 1'b1;

      tick(1'b0, 2'd0, 1'b0, 6'd0, "idle3");
      bgm_v = 1;
      hold(10, 2'd1, 1'b0, 6'd8, "bgm_post0");
      hold(10, 2'd1, 1'b0, 6'd8, "bgm_post1");
      hold(10, 2'd1, 1'b0, 6'd12, "bgm_post2");

      @(posedge clk);
      #2;
      check("queue_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
